// File: rtl/magnetron_pkg.sv
// Shared types and constants for the magnetron controller: state encoding,
// default power width and the PWM period helper.
package magnetron_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_COOK  = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam int PWR_W_DEFAULT = 4;
    localparam int SYNC_STAGES   = 2;

    // Control inputs that go through the optional synchroniser, in bit order
    // {timer_done, clearn, stopn, startn}, with their inactive levels.
    localparam int          SYNC_BITS = 4;
    localparam logic [3:0]  SYNC_IDLE = 4'b0111;

    function automatic int pwm_period(input int width);
        return (1 << width) - 1;
    endfunction

endpackage

// File: rtl/magnetron_pwm.sv
// Free-running duty-cycle generator: counts 0..P-1 while run is high,
// output is high while the count is below duty.
module magnetron_pwm
    import magnetron_pkg::*;
#(
    parameter int PWR_W = PWR_W_DEFAULT
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             run,
    input  logic             clear,
    input  logic [PWR_W-1:0] duty,
    output logic             pwm
);

    localparam logic [PWR_W-1:0] CNT_LAST = PWR_W'(pwm_period(PWR_W) - 1);

    logic [PWR_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_reg <= '0;
        end else if (clear) begin
            cnt_reg <= '0;
        end else if (run) begin
            cnt_reg <= (cnt_reg == CNT_LAST) ? '0 : cnt_reg + 1'b1;
        end
    end

    // duty == P is always above the largest count, giving continuous on-time.
    assign pwm = (cnt_reg < duty);

endmodule

// File: rtl/magnetron_ctrl.sv
// Microwave magnetron controller: IDLE/COOK/PAUSE/DONE state machine plus
// PWM power control. Define MAGNETRON_SYNC_EN to synchronise the button/timer inputs.
module magnetron_ctrl
    import magnetron_pkg::*;
#(
    parameter int PWR_W = PWR_W_DEFAULT
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             startn,
    input  logic             stopn,
    input  logic             clearn,
    input  logic             door_closed,
    input  logic             timer_done,
    input  logic [PWR_W-1:0] power_level,
    output logic             mag_on,
    output logic [1:0]       state,
    output logic             done
);

    state_t           state_reg;
    logic [PWR_W-1:0] pwr_q;
    logic             done_reg;

    logic             s_startn;
    logic             s_stopn;
    logic             s_clearn;
    logic             s_timer_done;
    logic [SYNC_BITS-1:0] raw_in;
    logic [SYNC_BITS-1:0] sync_bits;

    logic             start_ok;
    logic             cook_hold;
    logic             pwm;

    assign raw_in = {timer_done, clearn, stopn, startn};

`ifdef MAGNETRON_SYNC_EN
    genvar gi;
    generate
        for (gi = 0; gi < SYNC_BITS; gi++) begin : g_sync
            logic meta_reg;
            logic out_reg;

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    meta_reg <= SYNC_IDLE[gi];
                    out_reg  <= SYNC_IDLE[gi];
                end else begin
                    meta_reg <= raw_in[gi];
                    out_reg  <= meta_reg;
                end
            end

            assign sync_bits[gi] = out_reg;
        end
    endgenerate
`else
    assign sync_bits = raw_in;
`endif

    assign s_startn     = sync_bits[0];
    assign s_stopn      = sync_bits[1];
    assign s_clearn     = sync_bits[2];
    assign s_timer_done = sync_bits[3];

    assign start_ok = !s_startn && s_stopn && s_clearn && door_closed &&
                      !s_timer_done && (power_level != '0);

    // The counter only advances in cycles that stay in COOK, so a pause
    // resumes at exactly the count where it was interrupted.
    assign cook_hold = (state_reg == ST_COOK) && s_clearn && !s_timer_done &&
                       s_stopn && door_closed;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= ST_IDLE;
            pwr_q     <= '0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start_ok) begin
                        state_reg <= ST_COOK;
                        pwr_q     <= power_level;
                    end
                end
                ST_COOK: begin
                    if (!s_clearn) begin
                        state_reg <= ST_IDLE;
                    end else if (s_timer_done) begin
                        state_reg <= ST_DONE;
                        done_reg  <= 1'b1;
                    end else if (!s_stopn || !door_closed) begin
                        state_reg <= ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (!s_clearn) begin
                        state_reg <= ST_IDLE;
                    end else if (s_timer_done) begin
                        state_reg <= ST_DONE;
                        done_reg  <= 1'b1;
                    end else if (!s_startn && s_stopn && door_closed) begin
                        state_reg <= ST_COOK;
                    end
                end
                ST_DONE: begin
                    if (!s_clearn || !door_closed) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    magnetron_pwm #(
        .PWR_W (PWR_W)
    ) u_pwm (
        .clk    (clk),
        .resetn (resetn),
        .run    (cook_hold),
        .clear  (state_reg == ST_IDLE),
        .duty   (pwr_q),
        .pwm    (pwm)
    );

    // Door gating is deliberately combinational so opening the door kills
    // the magnetron without waiting for a clock edge.
    assign mag_on = (state_reg == ST_COOK) && door_closed && pwm;
    assign state  = state_reg;
    assign done   = done_reg;

endmodule

// File: tb/tb_magnetron_ctrl.sv
// Directed bench for magnetron_ctrl (PWR_W=4, P=15); latencies adapt when
// MAGNETRON_SYNC_EN is defined.
module tb_magnetron_ctrl;

`ifdef MAGNETRON_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] COOK  = 2'b01;
    localparam logic [1:0] PAUSE = 2'b10;
    localparam logic [1:0] DONE  = 2'b11;

    logic       clk;
    logic       resetn;
    logic       startn;
    logic       stopn;
    logic       clearn;
    logic       door_closed;
    logic       timer_done;
    logic [3:0] power_level;
    logic       mag_on;
    logic [1:0] state;
    logic       done;

    int checks = 0;
    int errors = 0;
    logic [31:0] pat;

    magnetron_ctrl #(.PWR_W(4)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .startn      (startn),
        .stopn       (stopn),
        .clearn      (clearn),
        .door_closed (door_closed),
        .timer_done  (timer_done),
        .power_level (power_level),
        .mag_on      (mag_on),
        .state       (state),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-16s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic sample(input int n, output logic [31:0] p);
        p = '0;
        for (int i = 0; i < n; i++) begin
            p[i] = mag_on;
            cyc(1);
        end
    endtask

    // One-cycle low pulse on a button, then wait until the FSM has reacted.
    task automatic pulse_startn();
        startn = 1'b0; cyc(1); startn = 1'b1;
        if (LAT > 1) cyc(LAT - 1);
    endtask

    initial begin
        resetn = 1'b0; startn = 1'b1; stopn = 1'b1; clearn = 1'b1;
        door_closed = 1'b1; timer_done = 1'b0; power_level = 4'd5;

        cyc(2);
        chk("rst_state", 32'(state), 32'(IDLE));
        chk("rst_mag_on", 32'(mag_on), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        resetn = 1'b1;
        cyc(2);

        // Zero power must not start.
        power_level = 4'd0;
        pulse_startn();
        chk("pl0_idle", 32'(state), 32'(IDLE));

        // power 5: 5 on / 10 off, two periods, power change ignored in second.
        power_level = 4'd5;
        pulse_startn();
        chk("start_cook", 32'(state), 32'(COOK));
        sample(15, pat);
        chk("pwm5_p1", pat, 32'h0000_001F);
        power_level = 4'd2;
        sample(15, pat);
        chk("pwm5_p2_pl2", pat, 32'h0000_001F);

        // Door opens at cnt=3.
        cyc(3);
        chk("cnt3_on", 32'(mag_on), 32'd1);
        door_closed = 1'b0; #1;
        chk("door_kill", 32'(mag_on), 32'd0);
        chk("door_still_cook", 32'(state), 32'(COOK));
        cyc(1);
        chk("door_pause", 32'(state), 32'(PAUSE));
        door_closed = 1'b1; #1;
        chk("pause_mag_off", 32'(mag_on), 32'd0);
        pulse_startn();
        chk("resume_cook", 32'(state), 32'(COOK));
        // resumed at cnt=3: counts 3,4 on, 5..14 off, 0..2 on
        sample(15, pat);
        chk("resume_cnt3", pat, 32'h0000_7003);

        // timer_done and stop together -> DONE wins.
        timer_done = 1'b1; stopn = 1'b0; cyc(1);
        timer_done = 1'b0; stopn = 1'b1;
        if (LAT > 1) cyc(LAT - 1);
        chk("done_state", 32'(state), 32'(DONE));
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_mag_off", 32'(mag_on), 32'd0);
        cyc(1);
        chk("done_1cyc", 32'(done), 32'd0);
        pulse_startn();
        chk("done_ign_start", 32'(state), 32'(DONE));
        stopn = 1'b0; cyc(LAT + 1); stopn = 1'b1;
        chk("done_ign_stop", 32'(state), 32'(DONE));
        clearn = 1'b0; cyc(1); clearn = 1'b1;
        if (LAT > 1) cyc(LAT - 1);
        chk("done_clear", 32'(state), 32'(IDLE));
        chk("idle_mag_off", 32'(mag_on), 32'd0);

        // Full power.
        power_level = 4'd15;
        pulse_startn();
        chk("full_cook", 32'(state), 32'(COOK));
        sample(20, pat);
        chk("full_power", pat, 32'h000F_FFFF);

        // Asynchronous reset mid-COOK, between clock edges.
        #1 resetn = 1'b0; #1;
        chk("arst_mag_on", 32'(mag_on), 32'd0);
        chk("arst_state", 32'(state), 32'(IDLE));
        chk("arst_cnt", 32'(dut.u_pwm.cnt_reg), 32'd0);
        cyc(2);
        resetn = 1'b1;
        cyc(4);
        chk("post_rst_idle", 32'(state), 32'(IDLE));
        chk("post_rst_off", 32'(mag_on), 32'd0);

        // Fresh start counts from 0; stop then clear from PAUSE.
        power_level = 4'd3;
        pulse_startn();
        sample(15, pat);
        chk("pwm3", pat, 32'h0000_0007);
        stopn = 1'b0; cyc(1); stopn = 1'b1;
        if (LAT > 1) cyc(LAT - 1);
        chk("stop_pause", 32'(state), 32'(PAUSE));
        clearn = 1'b0; cyc(1); clearn = 1'b1;
        if (LAT > 1) cyc(LAT - 1);
        chk("pause_clear", 32'(state), 32'(IDLE));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/magnetron_ctrl.md
MAGNETRON_CTRL -- requirements
Module: magnetron_ctrl

Interface
REQ-001 Parameter PWR_W, default 4: power-level width; PWM period P = 2^PWR_W - 1 cycles.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 startn  input  1  start button, active low.
REQ-005 stopn  input  1  stop/pause button, active low.
REQ-006 clearn  input  1  clear button, active low.
REQ-007 door_closed  input  1  1 = door closed.
REQ-008 timer_done  input  1  1 = cook timer expired.
REQ-009 power_level  input  PWR_W  requested duty; 0 = invalid, P = full power.
REQ-010 mag_on  output  1  magnetron enable.
REQ-011 state  output  2  IDLE=00, COOK=01, PAUSE=10, DONE=11.
REQ-012 done  output  1  one-cycle pulse on entry to DONE.

Function
REQ-013 FSM transitions SHALL be registered; one clk from qualifying inputs to new state.
REQ-014 IDLE->COOK: !startn & stopn & clearn & door_closed & !timer_done & power_level!=0; otherwise stay IDLE.
REQ-015 On IDLE->COOK, power_level SHALL be latched into pwr_q and the PWM counter cleared to 0; later power_level changes ignored until next IDLE->COOK.
REQ-016 COOK priority, highest first: !clearn -> IDLE; timer_done -> DONE; (!stopn or !door_closed) -> PAUSE; else stay.
REQ-017 PAUSE priority: !clearn -> IDLE; timer_done -> DONE; (!startn & stopn & door_closed) -> COOK (resume, pwr_q and counter kept); else stay.
REQ-018 DONE: !clearn or !door_closed -> IDLE; otherwise stay; start ignored.
REQ-019 done SHALL be 1 exactly in the first cycle state reads DONE.
REQ-020 PWM counter SHALL increment only in COOK, wrap from P-1 to 0, hold in PAUSE/DONE, clear in IDLE.
REQ-021 mag_on = (state==COOK) & door_closed & (cnt < pwr_q); door_closed gating SHALL be combinational (zero latency), not synchronised.
REQ-022 pwr_q = P SHALL give mag_on continuously high throughout COOK.
REQ-023 mag_on SHALL never be 1 in IDLE, PAUSE or DONE, or while door_closed=0.
REQ-024 stopn held low in IDLE/DONE SHALL have no effect.

Reset
REQ-025 resetn low: state=IDLE, cnt=0, pwr_q=0, mag_on=0, done=0, synchroniser flops cleared, immediately and regardless of clk.
REQ-026 Reset asserted mid-COOK SHALL drop mag_on in the same instant; release returns to IDLE, no auto-resume.

Configuration
REQ-027 Macro MAGNETRON_SYNC_EN: when defined, startn, stopn, clearn, timer_done pass through 2-flop synchronisers (reset to inactive levels) before the FSM, adding 2 cycles latency; door_closed gating of mag_on stays unsynchronised.
REQ-028 Without MAGNETRON_SYNC_EN, the FSM consumes the inputs directly (REQ-013 latency).

Structure
REQ-029 Package magnetron_pkg SHALL hold the state encoding typedef and the state constants.
REQ-030 Sub-module magnetron_pwm (parameter PWR_W; inputs run, clear, duty; output pwm) SHALL implement the counter and compare; the FSM stays in magnetron_ctrl.

Verification (PWR_W=4, P=15, no macro unless stated)
REQ-031 Door closed, power_level=5, startn low 1 cycle -> state=COOK next cycle; mag_on high 5 of every 15 cycles, repeating.
REQ-032 In COOK at cnt=3, door_closed->0 -> mag_on 0 same cycle, state=PAUSE next; close door, pulse startn -> COOK resumes at cnt=3.
REQ-033 In COOK, timer_done=1 and stopn=0 same cycle -> DONE, done high 1 cycle, mag_on 0; clearn low -> IDLE.
REQ-034 power_level=0 with valid start -> stays IDLE; power_level=15 -> mag_on constant 1 in COOK; changing power_level to 2 mid-COOK -> duty unchanged.
REQ-035 resetn low mid-COOK -> mag_on, state, cnt all 0 asynchronously; after release, no activity until new start.
REQ-036 With MAGNETRON_SYNC_EN: start pulse -> COOK 3 cycles later; door opening still forces mag_on 0 immediately.
